data_bus_responder: RTL

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

---
 rtl/data_bus_responder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/data_bus_responder.sv
// Memory-mapped data bus responder: word RAM plus an output and a synchronized input port,
// answering each accepted load/store with a one-cycle Ready after a fixed number of wait states.
module data_bus_responder #(
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter int unsigned WAIT_STATES  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        BusError,
  output logic [31:0] PortOut
);

  localparam int unsigned AW = $clog2(MEMORY_DEPTH);
  localparam int unsigned CW = 4;
  localparam logic [31:0] RAM_BASE     = 32'h1001_0000;
  localparam logic [31:0] RAM_LAST     = RAM_BASE + 32'(4 * MEMORY_DEPTH) - 32'd1;
  localparam logic [31:0] PORTOUT_ADDR = 32'h1001_FFF0;
  localparam logic [31:0] PORTIN_ADDR  = 32'h1001_FFF4;
  localparam logic [CW-1:0] WAIT_LAST  = CW'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;
  logic            lat_read;
  logic            lat_write;
  logic            lat_both;
  logic [7:0]      sync1;
  logic [7:0]      sync2;
  logic [31:0]     mem [MEMORY_DEPTH];

  logic            req;
  logic [31:0]     cur_addr;
  logic            cur_read;
  logic            cur_write;
  logic            cur_both;
  logic            ram_hit;
  logic            pout_hit;
  logic            pin_hit;
  logic            misaligned;
  logic            acc_err;
  logic [AW-1:0]   ram_idx;
  logic [31:0]     rd_data;
  logic            enter_resp;
  logic            commit;

  assign req = MemRead | MemWrite;

  // With zero wait states the response is decided in IDLE, before the latches hold the request.
  always_comb begin
    cur_addr  = lat_addr;
    cur_read  = lat_read;
    cur_write = lat_write;
    cur_both  = lat_both;
    if (state == IDLE) begin
      cur_addr  = Address;
      cur_read  = MemRead & ~MemWrite;
      cur_write = MemWrite & ~MemRead;
      cur_both  = MemRead & MemWrite;
    end
  end

  assign ram_hit    = (cur_addr >= RAM_BASE) && (cur_addr <= RAM_LAST);
  assign pout_hit   = (cur_addr == PORTOUT_ADDR);
  assign pin_hit    = (cur_addr == PORTIN_ADDR);
  assign misaligned = |cur_addr[1:0];
  assign acc_err    = cur_both | misaligned | ~(ram_hit | pout_hit | pin_hit)
                    | (cur_write & pin_hit);
  assign ram_idx    = cur_addr[AW+1:2];

  always_comb begin
    rd_data = 32'd0;
    if (ram_hit) begin
      rd_data = mem[ram_idx];
    end else if (pout_hit) begin
      rd_data = PortOut;
    end else if (pin_hit) begin
      rd_data = {24'd0, sync2};
    end
  end

  assign enter_resp = ((state == IDLE) && req && NO_WAIT)
                    || ((state == WAIT) && (wait_cnt == WAIT_LAST));

  // Writes take effect on the edge leaving RESP; BusError already holds this access's verdict.
  assign commit = (state == RESP) && lat_write && !BusError;

  // Control FSM, response registers, output port and input synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_both  <= 1'b0;
      Ready     <= 1'b0;
      BusError  <= 1'b0;
      ReadData  <= 32'd0;
      PortOut   <= 32'd0;
      sync1     <= 8'd0;
      sync2     <= 8'd0;
    end else begin
      sync1    <= PortIn;
      sync2    <= sync1;
      Ready    <= 1'b0;
      BusError <= 1'b0;

      case (state)
        IDLE: begin
          if (req) begin
            lat_addr  <= Address;
            lat_wdata <= WriteData;
            lat_read  <= MemRead & ~MemWrite;
            lat_write <= MemWrite & ~MemRead;
            lat_both  <= MemRead & MemWrite;
            wait_cnt  <= '0;
            state     <= NO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          if (commit && pout_hit) begin
            PortOut <= lat_wdata;
          end
        end
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        Ready    <= 1'b1;
        BusError <= acc_err;
        if (acc_err) begin
          ReadData <= 32'd0;
        end else if (cur_read) begin
          ReadData <= rd_data;
        end
      end
    end
  end

  // Data RAM is deliberately left uninitialized by reset.
  always_ff @(posedge clk) begin
    if (!reset && commit && ram_hit) begin
      mem[ram_idx] <= lat_wdata;
    end
  end

endmodule
